// File: rtl/multicycle_control.sv
// Moore controller for the multicycle MIPS datapath; CTRL_ILLEGAL_TRAP_EN adds a sticky illegal-opcode trap.
// Latency: controls are registered and decode the current state; 3-5 cycles per instruction.
// Backpressure: en=0 freezes state and the retire counter and masks every write strobe.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic [CNT_W-1:0] instr_count
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    state_t state, state_nxt;
    ctrl_t  ctrl;

    logic unused_funct;
    assign unused_funct = ^Funct;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BRANCH:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_nxt = S_TRAP;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_nxt = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_nxt = S_MEMWB;
            S_EXECUTE: state_nxt = S_ALUWB;
            S_ADDIEX:  state_nxt = S_ADDIWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:    state_nxt = S_TRAP;
`endif
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Outputs are registered alongside the state so they always decode the state just entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH;
            ctrl        <= decode(S_FETCH);
            instr_count <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else if (en) begin
            state <= state_nxt;
            ctrl  <= decode(state_nxt);
            // FETCH is only ever re-entered from a finished instruction (or a DECODE NOP).
            if (state_nxt == S_FETCH)
                instr_count <= instr_count + 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal <= (state_nxt == S_TRAP);
`endif
        end
    end

    assign IorD     = ctrl.iord;
    assign ALUSrcA  = ctrl.alusrca;
    assign ALUSrcB  = ctrl.alusrcb;
    assign PCSrc    = ctrl.pcsrc;
    assign RegDst   = ctrl.regdst;
    assign MemtoReg = ctrl.memtoreg;
    assign ALUOp    = ctrl.aluop;
    assign IRWrite  = ctrl.irwrite  & en;
    assign PCWrite  = ctrl.pcwrite  & en;
    assign MemWrite = ctrl.memwrite & en & reset;
    assign RegWrite = ctrl.regwrite & en & reset;
    assign Branch   = ctrl.branch   & en & reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected control words queued per instruction, compared per cycle.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic             en;
    logic [5:0]       OP;
    logic [5:0]       Funct;
    logic             IorD, ALUSrcA, IRWrite, PCWrite, MemWrite;
    logic             RegDst, MemtoReg, RegWrite, Branch;
    logic [1:0]       ALUSrcB, PCSrc, ALUOp;
    logic [CNT_W-1:0] instr_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             illegal;
`endif

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .OP(OP), .Funct(Funct),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Branch(Branch), .ALUOp(ALUOp), .instr_count(instr_count)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    // {IorD, ALUSrcA, ALUSrcB, PCSrc, IRWrite, PCWrite, MemWrite, RegDst, MemtoReg, RegWrite, Branch, ALUOp}
    localparam logic [14:0] C_FETCH  = 15'b0_0_01_00_1_1_0_0_0_0_0_00;
    localparam logic [14:0] C_DECODE = 15'b0_0_11_00_0_0_0_0_0_0_0_00;
    localparam logic [14:0] C_MEMADR = 15'b0_1_10_00_0_0_0_0_0_0_0_00;
    localparam logic [14:0] C_MEMRD  = 15'b1_0_00_00_0_0_0_0_0_0_0_00;
    localparam logic [14:0] C_MEMWB  = 15'b0_0_00_00_0_0_0_0_1_1_0_00;
    localparam logic [14:0] C_MEMWR  = 15'b1_0_00_00_0_0_1_0_0_0_0_00;
    localparam logic [14:0] C_EXEC   = 15'b0_1_00_00_0_0_0_0_0_0_0_10;
    localparam logic [14:0] C_ALUWB  = 15'b0_0_00_00_0_0_0_1_0_1_0_00;
    localparam logic [14:0] C_BRANCH = 15'b0_1_00_01_0_0_0_0_0_0_1_01;
    localparam logic [14:0] C_ADDIEX = 15'b0_1_10_00_0_0_0_0_0_0_0_00;
    localparam logic [14:0] C_ADDIWB = 15'b0_0_00_00_0_0_0_0_0_1_0_00;
    localparam logic [14:0] C_JUMP   = 15'b0_0_00_10_0_1_0_0_0_0_0_00;
    localparam logic [14:0] STROBES  = 15'b0_0_00_00_1_1_1_0_0_1_1_00;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    logic [14:0] obs_ctrl;
    assign obs_ctrl = {IorD, ALUSrcA, ALUSrcB, PCSrc, IRWrite, PCWrite, MemWrite,
                       RegDst, MemtoReg, RegWrite, Branch, ALUOp};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;
    logic [14:0] sb[$];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [14:0] w);
        check(tag, {17'd0, obs_ctrl}, {17'd0, w});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (sb.size() > 0) begin
            step($sformatf("%s_c%0d", name, i), sb.pop_front());
            i++;
        end
    endtask

    task automatic retire(input string name);
        exp_cnt++;
        check({name, "_cnt"}, instr_count, exp_cnt);
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        OP    = OP_LW;
        Funct = 6'b100000;
        #12;
        check("rst_ctrl", {17'd0, obs_ctrl}, {17'd0, C_FETCH});
        check("rst_cnt", instr_count, 32'd0);
        #3 reset = 1'b1;
        #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("rst_illegal", {31'd0, illegal}, 32'd0);
`endif

        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_MEMADR);
        sb.push_back(C_MEMRD); sb.push_back(C_MEMWB);
        drain("lw");
        retire("lw");

        OP = OP_SW;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_MEMADR); sb.push_back(C_MEMWR);
        drain("sw");
        retire("sw");

        OP = OP_RT;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_EXEC); sb.push_back(C_ALUWB);
        drain("rtype");
        retire("rtype");
        OP = OP_ADDI;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_ADDIEX); sb.push_back(C_ADDIWB);
        drain("addi");
        retire("addi");
        OP = OP_BEQ;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_BRANCH);
        drain("beq");
        retire("beq");
        OP = OP_J;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_JUMP);
        drain("j");
        retire("j");

        // Stall in FETCH (strobes masked), then stall in MEMADR for three cycles.
        OP = OP_LW;
        en = 1'b0;
        #1;
        step("stall_fetch0", C_FETCH & ~STROBES);
        step("stall_fetch1", C_FETCH & ~STROBES);
        en = 1'b1;
        #1;
        step("stall_lw_f", C_FETCH);
        step("stall_lw_d", C_DECODE);
        check("stall_lw_ma", {17'd0, obs_ctrl}, {17'd0, C_MEMADR});
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_hold%0d", k), {17'd0, obs_ctrl}, {17'd0, C_MEMADR & ~STROBES});
            check($sformatf("stall_cnt%0d", k), instr_count, exp_cnt);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(C_MEMRD); sb.push_back(C_MEMWB);
        drain("stall_resume");
        retire("stall");

        // Asynchronous reset in the middle of an RTYPE.
        OP = OP_RT;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE);
        drain("abort");
        check("abort_exec", {17'd0, obs_ctrl}, {17'd0, C_EXEC});
        #1 reset = 1'b0;
        #1;
        check("abort_ctrl", {17'd0, obs_ctrl}, {17'd0, C_FETCH});
        check("abort_cnt", instr_count, 32'd0);
        exp_cnt = 0;
        #1 reset = 1'b1;
        #1;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_EXEC); sb.push_back(C_ALUWB);
        drain("after_abort");
        retire("after_abort");

        // Unknown opcode.
        OP = 6'b111111;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE);
        drain("illop");
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            en = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("trap_ctrl%0d", k), {17'd0, obs_ctrl}, 32'd0);
            check($sformatf("trap_flag%0d", k), {31'd0, illegal}, 32'd1);
            check($sformatf("trap_cnt%0d", k), instr_count, exp_cnt);
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        reset = 1'b0;
        #1;
        check("trap_rst_flag", {31'd0, illegal}, 32'd0);
        check("trap_rst_ctrl", {17'd0, obs_ctrl}, {17'd0, C_FETCH});
        reset = 1'b1;
        exp_cnt = 0;
        #1;
`else
        retire("nop");
`endif
        OP = OP_BEQ;
        sb.push_back(C_FETCH); sb.push_back(C_DECODE); sb.push_back(C_BRANCH);
        drain("final");
        retire("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
